// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_STATS_EN to build per-requester accepted-beat counters.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int SEL_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BURST_W   = $clog2(MAX_BURST + 1)
) (
    input  logic                          wrclk,
    input  logic                          wrrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ready,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [SEL_W-1:0]              stat_sel,
    output logic [CNT_WIDTH-1:0]          stat_cnt
);

    // state | meaning
    // IDLE  | no grant held, arbitrating on any req
    // GRANT | gnt_idx owns the write port for up to MAX_BURST beats
    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_n;
    logic [NUM_REQ-1:0]   gnt_n;
    logic                 busy_n;
    logic [BURST_W-1:0]   burst_cnt, burst_n;
    logic [SEL_W-1:0]     last_gnt, last_n;
    logic [SEL_W-1:0]     gnt_idx, idx_n;
    logic [SEL_W-1:0]     scan_base;
    logic [SEL_W-1:0]     win_idx;
    logic                 win_found;
    logic                 accept;
    logic                 rel;

    // While granted, scan from the current owner so it re-wins only when alone.
    always_comb begin
        scan_base = (state == GRANT) ? gnt_idx : last_gnt;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req[(int'(scan_base) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = SEL_W'((int'(scan_base) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == GRANT && !wrrst)
            ready[gnt_idx] = req[gnt_idx] & ~fifo_full;
    end

    assign accept  = |(ready & req);
    assign wr_en   = accept;
    assign wr_data = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        busy_n  = busy;
        burst_n = burst_cnt;
        last_n  = last_gnt;
        idx_n   = gnt_idx;
        rel     = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n        = GRANT;
                    gnt_n          = '0;
                    gnt_n[win_idx] = 1'b1;
                    idx_n          = win_idx;
                    busy_n         = 1'b1;
                    burst_n        = '0;
                end
            end
            GRANT: begin
                rel = (accept && burst_cnt == BURST_W'(MAX_BURST - 1)) || !req[gnt_idx];
                if (accept)
                    burst_n = burst_cnt + 1'b1;
                if (rel) begin
                    last_n  = gnt_idx;
                    burst_n = '0;
                    if (win_found) begin
                        gnt_n          = '0;
                        gnt_n[win_idx] = 1'b1;
                        idx_n          = win_idx;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wrclk) begin
        if (wrrst) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
            last_gnt  <= SEL_W'(NUM_REQ - 1);
            gnt_idx   <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            busy      <= busy_n;
            burst_cnt <= burst_n;
            last_gnt  <= last_n;
            gnt_idx   <= idx_n;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] beat_cnt [NUM_REQ];
    logic [CNT_WIDTH-1:0] stat_q;

    always_ff @(posedge wrclk) begin
        if (wrrst) begin
            for (int i = 0; i < NUM_REQ; i++)
                beat_cnt[i] <= '0;
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (ready[i] && req[i] && beat_cnt[i] != '1)
                    beat_cnt[i] <= beat_cnt[i] + 1'b1;
            if (int'(stat_sel) < NUM_REQ)
                stat_q <= beat_cnt[stat_sel];
            else
                stat_q <= '0;
        end
    end

    assign stat_cnt = stat_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter at default parameters.
// Requesters present data (i+1)*16 + beat_number and advance on req&ready.
module tb_fifo_wr_arbiter;

    logic        wrclk = 1'b0;
    logic        wrrst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ready;
    logic [3:0]  gnt;
    logic        busy;
    logic        fifo_full;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;

    int checks = 0;
    int errors = 0;
    int beats [4];

    always #5 wrclk = ~wrclk;

    fifo_wr_arbiter dut (
        .wrclk    (wrclk),
        .wrrst    (wrrst),
        .req      (req),
        .req_data (req_data),
        .ready    (ready),
        .gnt      (gnt),
        .busy     (busy),
        .fifo_full(fifo_full),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .stat_sel (stat_sel),
        .stat_cnt (stat_cnt)
    );

    task automatic drive_data();
        for (int i = 0; i < 4; i++)
            req_data[i*8 +: 8] = 8'((i + 1) * 16 + beats[i]);
    endtask

    // Called after the negedge checks; moves to just past the next rising edge.
    task automatic advance();
        logic [3:0] acc;
        acc = req & ready;
        @(posedge wrclk);
        #1;
        for (int i = 0; i < 4; i++)
            if (acc[i]) beats[i]++;
        drive_data();
    endtask

    task automatic do_reset();
        wrrst     = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        stat_sel  = '0;
        for (int i = 0; i < 4; i++) beats[i] = 0;
        drive_data();
        @(posedge wrclk); #1;
        @(posedge wrclk); #1;
        wrrst = 1'b0;
    endtask

    task automatic test_reset();
        wrrst     = 1'b1;
        req       = 4'b1111;
        fifo_full = 1'b0;
        stat_sel  = 2'd1;
        for (int i = 0; i < 4; i++) beats[i] = 0;
        drive_data();
        @(posedge wrclk); #1;
        @(posedge wrclk); #1;
        @(negedge wrclk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b busy=%b expected gnt=0000 busy=0", gnt, busy);
        end
        checks++;
        if (wr_en !== 1'b0 || ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: wr_en=%b ready=%b expected 0 / 0000", wr_en, ready);
        end
        checks++;
        if (stat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stat: stat_cnt=%0d expected 0", stat_cnt);
        end
        wrrst = 1'b0;
        req   = '0;
    endtask

    task automatic test_single_requester();
        do_reset();
        req = 4'b0001;
        @(negedge wrclk);
        checks++;
        if (gnt !== 4'b0000 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_arb_cycle: gnt=%b wr_en=%b expected 0000 / 0", gnt, wr_en);
        end
        advance();
        for (int k = 0; k < 6; k++) begin
            @(negedge wrclk);
            checks++;
            if (gnt !== 4'b0001 || busy !== 1'b1 || ready !== 4'b0001) begin
                errors++;
                $display("FAIL single_grant beat %0d: gnt=%b busy=%b ready=%b expected 0001/1/0001",
                         k, gnt, busy, ready);
            end
            checks++;
            if (wr_en !== 1'b1 || wr_data !== 8'(8'h10 + k)) begin
                errors++;
                $display("FAIL single_beat %0d: wr_en=%b data=%h expected 1 / %h",
                         k, wr_en, wr_data, 8'(8'h10 + k));
            end
            advance();
        end
        req = '0;
        @(negedge wrclk);
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_drop: wr_en=%b busy=%b expected 0 / 1", wr_en, busy);
        end
        advance();
        @(negedge wrclk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: gnt=%b busy=%b expected 0000 / 0", gnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        int exp_beats [4];
        int g;
        do_reset();
        for (int i = 0; i < 4; i++) exp_beats[i] = 0;
        req = 4'b1111;
        @(negedge wrclk);
        advance();
        for (int b = 0; b < 20; b++) begin
            g = (b / 4) % 4;
            @(negedge wrclk);
            checks++;
            if (gnt !== 4'(1 << g) || wr_en !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_grant beat %0d: gnt=%b wr_en=%b busy=%b expected %b/1/1",
                         b, gnt, wr_en, busy, 4'(1 << g));
            end
            checks++;
            if (wr_data !== 8'((g + 1) * 16 + exp_beats[g])) begin
                errors++;
                $display("FAIL b2b_data beat %0d: data=%h expected %h",
                         b, wr_data, 8'((g + 1) * 16 + exp_beats[g]));
            end
            exp_beats[g]++;
            advance();
        end
        req = '0;
        @(negedge wrclk);
        checks++;
        if (gnt !== 4'b0010 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_next_owner: gnt=%b wr_en=%b expected 0010 / 0", gnt, wr_en);
        end
        advance();
    endtask

    task automatic test_fifo_full_stall();
        do_reset();
        req = 4'b0100;
        @(negedge wrclk);
        advance();
        for (int k = 0; k < 2; k++) begin
            @(negedge wrclk);
            checks++;
            if (wr_en !== 1'b1 || wr_data !== 8'(8'h30 + k) || gnt !== 4'b0100) begin
                errors++;
                $display("FAIL full_pre beat %0d: wr_en=%b data=%h gnt=%b expected 1/%h/0100",
                         k, wr_en, wr_data, gnt, 8'(8'h30 + k));
            end
            advance();
        end
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge wrclk);
            checks++;
            if (wr_en !== 1'b0 || ready !== 4'b0000 || gnt !== 4'b0100 || busy !== 1'b1) begin
                errors++;
                $display("FAIL full_stall cycle %0d: wr_en=%b ready=%b gnt=%b busy=%b expected 0/0000/0100/1",
                         k, wr_en, ready, gnt, busy);
            end
            advance();
        end
        fifo_full = 1'b0;
        for (int k = 2; k < 4; k++) begin
            @(negedge wrclk);
            checks++;
            if (wr_en !== 1'b1 || wr_data !== 8'(8'h30 + k) || gnt !== 4'b0100) begin
                errors++;
                $display("FAIL full_post beat %0d: wr_en=%b data=%h gnt=%b expected 1/%h/0100",
                         k, wr_en, wr_data, gnt, 8'(8'h30 + k));
            end
            advance();
        end
        req = '0;
        @(negedge wrclk);
        checks++;
        if (beats[2] !== 4 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL full_total: beats=%0d wr_en=%b expected 4 / 0", beats[2], wr_en);
        end
        advance();
    endtask

    task automatic test_drop_release();
        do_reset();
        req = 4'b1010;
        @(negedge wrclk);
        advance();
        @(negedge wrclk);
        checks++;
        if (gnt !== 4'b0010 || wr_en !== 1'b1 || wr_data !== 8'h20) begin
            errors++;
            $display("FAIL drop_first: gnt=%b wr_en=%b data=%h expected 0010/1/20", gnt, wr_en, wr_data);
        end
        advance();
        req = 4'b1000;
        @(negedge wrclk);
        checks++;
        if (wr_en !== 1'b0 || ready !== 4'b0000) begin
            errors++;
            $display("FAIL drop_cycle: wr_en=%b ready=%b expected 0 / 0000", wr_en, ready);
        end
        advance();
        @(negedge wrclk);
        checks++;
        if (gnt !== 4'b1000 || wr_en !== 1'b1 || wr_data !== 8'h40) begin
            errors++;
            $display("FAIL drop_regrant: gnt=%b wr_en=%b data=%h expected 1000/1/40", gnt, wr_en, wr_data);
        end
        advance();
        req = '0;
        @(negedge wrclk);
        advance();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0101;
        @(negedge wrclk);
        advance();
        for (int k = 0; k < 4; k++) begin
            @(negedge wrclk);
            advance();
        end
        @(negedge wrclk);
        checks++;
        if (gnt !== 4'b0100 || wr_en !== 1'b1 || wr_data !== 8'h30) begin
            errors++;
            $display("FAIL rst_pre: gnt=%b wr_en=%b data=%h expected 0100/1/30", gnt, wr_en, wr_data);
        end
        advance();
        wrrst = 1'b1;
        @(negedge wrclk);
        checks++;
        if (wr_en !== 1'b0 || ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_cycle_write: wr_en=%b ready=%b expected 0 / 0000", wr_en, ready);
        end
        advance();
        @(negedge wrclk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_dropped: gnt=%b busy=%b wr_en=%b expected 0000/0/0", gnt, busy, wr_en);
        end
        advance();
        wrrst = 1'b0;
        @(negedge wrclk);
        advance();
        @(negedge wrclk);
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_grant: gnt=%b busy=%b expected 0001 / 1", gnt, busy);
        end
        req = '0;
        advance();
        @(negedge wrclk);
        advance();
    endtask

    task automatic test_stats();
        logic [15:0] exp_cnt;
`ifdef FIFO_WR_ARB_STATS_EN
        exp_cnt = 16'd6;
`else
        exp_cnt = 16'd0;
`endif
        do_reset();
        req = 4'b0010;
        @(negedge wrclk);
        advance();
        for (int k = 0; k < 6; k++) begin
            @(negedge wrclk);
            advance();
        end
        req = '0;
        @(negedge wrclk);
        advance();
        stat_sel = 2'd1;
        @(negedge wrclk);
        advance();
        @(negedge wrclk);
        checks++;
        if (stat_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL stat_req1: stat_cnt=%0d expected %0d", stat_cnt, exp_cnt);
        end
        stat_sel = 2'd0;
        advance();
        @(negedge wrclk);
        checks++;
        if (stat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stat_req0: stat_cnt=%0d expected 0", stat_cnt);
        end
    endtask

    initial begin
        wrrst     = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        stat_sel  = '0;
        test_reset();
        test_single_requester();
        test_back_to_back();
        test_fifo_full_stall();
        test_drop_release();
        test_reset_mid_burst();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
